// File: rtl/game_pkg.sv
// Shared types and value limits for the number-guessing game.
// Answers and legal guesses both live in VAL_MIN..VAL_MAX.
package game_pkg;

  localparam int VAL_MIN = 1;
  localparam int VAL_MAX = 8;
  localparam int VAL_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PLAY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    HINT_INVALID = 2'b00,
    HINT_LOW     = 2'b01,
    HINT_HIGH    = 2'b10,
    HINT_CORRECT = 2'b11
  } hint_t;

  function automatic logic in_range(input logic [VAL_W-1:0] v);
    return (v >= VAL_W'(VAL_MIN)) && (v <= VAL_W'(VAL_MAX));
  endfunction

endpackage

// File: rtl/answer_fetch.sv
// Request/strobe handshake with the answer generator: pulses change_answer,
// waits for a strobe with a bounded timeout and range-checks the value.
//
//   state  | meaning
//   S_IDLE | no fetch in progress
//   S_REQ  | change_answer high for this one cycle, timeout reloaded
//   S_WAIT | waiting for write_enable; re-request on timeout or bad value
module answer_fetch
  import game_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_go,
  input  logic             write_enable,
  input  logic [VAL_W-1:0] rand_lo,
  output logic             change_answer,
  output logic             ans_valid,
  output logic [VAL_W-1:0] ans,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (fetch_go) state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(TIMEOUT - 1);
      end
      S_WAIT: begin
        if (write_enable)
          state_d = in_range(rand_lo) ? S_IDLE : S_REQ;
        else if (cnt_q == '0)
          state_d = S_REQ;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Acceptance is combinational so the top enters PLAY on the strobe edge.
  assign ans_valid     = (state_q == S_WAIT) && write_enable && in_range(rand_lo);
  assign ans           = rand_lo;
  assign change_answer = (state_q == S_REQ);
  assign busy          = (state_q != S_IDLE);

endmodule

// File: rtl/answer_checker.sv
// Round controller: fetches an answer, scores guesses with up/down hints,
// counts down tries and reports win or lose.
//
//   state  | meaning
//   S_IDLE | after reset, waiting for start
//   S_REQ  | answer fetch in progress (REQ/WAIT handled by answer_fetch)
//   S_PLAY | scoring guesses against the latched answer
//   S_DONE | round decided, outcome held until the next start
module answer_checker
  import game_pkg::*;
#(
  parameter int MAX_TRIES = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        write_enable,
  input  logic [31:0] rand_num,      // generator value; "rand" is reserved in SV
  input  logic        guess_valid,
  input  logic [3:0]  guess,
  output logic        change_answer,
  output logic        result_valid,
  output logic [1:0]  hint,
  output logic [3:0]  tries_left,
  output logic        win,
  output logic        lose,
  output logic [3:0]  answer,
  output logic        busy
);

  state_t           state_q, state_d;
  logic [VAL_W-1:0] answer_q, answer_d;
  logic [3:0]       tries_q, tries_d;
  hint_t            hint_q, hint_d;
  logic             rv_q, rv_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;

  logic             fetch_go;
  logic             ans_valid;
  logic [VAL_W-1:0] ans;
  logic             unused_rand_hi;

  assign unused_rand_hi = ^rand_num[31:VAL_W];

  // Start is ignored while a fetch is already running.
  assign fetch_go = start && (state_q == S_IDLE || state_q == S_PLAY || state_q == S_DONE);

  answer_fetch #(.TIMEOUT(TIMEOUT)) u_fetch (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_go      (fetch_go),
    .write_enable  (write_enable),
    .rand_lo       (rand_num[VAL_W-1:0]),
    .change_answer (change_answer),
    .ans_valid     (ans_valid),
    .ans           (ans),
    .busy          (busy)
  );

  always_comb begin
    state_d  = state_q;
    answer_d = answer_q;
    tries_d  = tries_q;
    hint_d   = hint_q;
    rv_d     = 1'b0;
    win_d    = win_q;
    lose_d   = lose_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ: begin
        if (ans_valid) begin
          state_d  = S_PLAY;
          answer_d = ans;
          tries_d  = 4'(MAX_TRIES);
        end
      end
      S_PLAY: begin
        if (start) begin
          state_d = S_REQ;
        end else if (guess_valid) begin
          rv_d = 1'b1;
          if (!in_range(guess)) begin
            hint_d = HINT_INVALID;
          end else if (guess == answer_q) begin
            hint_d  = HINT_CORRECT;
            win_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            hint_d = (guess < answer_q) ? HINT_LOW : HINT_HIGH;
            if (tries_q != 4'd0) tries_d = tries_q - 4'd1;
            if (tries_q <= 4'd1) begin
              lose_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (start) begin
          win_d   = 1'b0;
          lose_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      answer_q <= '0;
      tries_q  <= '0;
      hint_q   <= HINT_INVALID;
      rv_q     <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      answer_q <= answer_d;
      tries_q  <= tries_d;
      hint_q   <= hint_d;
      rv_q     <= rv_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  assign result_valid = rv_q;
  assign hint         = hint_q;
  assign tries_left   = tries_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign answer       = (state_q == S_DONE) ? answer_q : 4'd0;

endmodule
